mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter: XLEN, default 32, operand/result width (matches register-file data width).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-004 SHALL have port: in_valid  input  1  request present.
REQ-005 SHALL have port: in_ready  output  1  unit can accept request.
REQ-006 SHALL have port: op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have port: rd  input  5  destination register index.
REQ-008 SHALL have port: src1 / src2  input  XLEN each  operands from register-file read ports data1/data2.
REQ-009 SHALL have port: flush  input  1  abort in-flight op, discard result.
REQ-010 SHALL have port: out_valid  output  1  result present; drives register-file RegWEn.
REQ-011 SHALL have port: out_ready  input  1  writeback accepts result.
REQ-012 SHALL have port: out_rd / out_data  output  5 / XLEN  register-file rd / dataW.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIX, DONE; in_ready = (state == IDLE), combinational from state only.
REQ-014 SHALL accept a request on an edge where state == IDLE, in_valid = 1 and flush = 0; op, rd and operand magnitudes latch on that edge.
REQ-015 Normal op: accept edge -> CALC; CALC runs exactly XLEN iterations (1 bit/edge, counter 0..XLEN-1); last iteration edge -> FIX; next edge -> DONE.
REQ-016 out_valid SHALL go high exactly XLEN+1 edges after accept edge (33 for XLEN=32).
REQ-017 Multiply SHALL be iterative shift-add on magnitudes into a 2*XLEN product, sign-corrected in FIX; MUL returns low XLEN bits, MULH/MULHSU/MULHU high XLEN bits. MULHSU: src1 signed, src2 unsigned.
REQ-018 Divide SHALL be iterative restoring on magnitudes; DIV/REM signed, DIVU/REMU unsigned; quotient truncates toward zero; remainder takes dividend's sign.
REQ-019 Divide by zero: quotient = all ones, remainder = src1; this and signed overflow (DIV/REM with src1 = 2^(XLEN-1), src2 = -1: quotient = src1, remainder = 0) SHALL bypass CALC/FIX, accept edge -> DONE, out_valid one edge after accept.
REQ-020 out_data / out_rd SHALL be registered, stable while out_valid = 1 and out_ready = 0.
REQ-021 When latched rd == 0, out_data SHALL be forced to 0 (x0 stays zero); out_valid still asserted.
REQ-022 DONE -> IDLE on edge with out_valid & out_ready; out_valid drops that edge; no accept in same edge (in_ready low in DONE).
REQ-023 flush = 1 in any state SHALL force IDLE on that edge, out_valid = 0 next cycle, no result delivered; flush beats in_valid.
REQ-024 Inputs src1/src2/op/rd SHALL be ignored outside the accept edge; changes mid-operation do not affect result.

Reset
REQ-025 rst = 0 on an edge SHALL force state IDLE, counter 0, out_valid 0, out_data 0, out_rd 0, internal accumulators 0; rst has priority over flush and in_valid.
REQ-026 Reset asserted mid-CALC or in DONE SHALL discard the operation; in_ready = 1 on first cycle after rst returns to 1.

Verification
REQ-027 MUL src1 = 7, src2 = 0xFFFFFFFD, rd = 5 -> out_valid after 33 edges, out_data 0xFFFFFFEB, out_rd 5.
REQ-028 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-029 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
REQ-030 DIVU 9 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0; each out_valid one edge after accept.
REQ-031 out_ready held 0 for 10 cycles in DONE -> out_valid, out_data, out_rd stable, in_ready 0; out_ready = 1 -> next cycle IDLE, in_ready 1.
REQ-032 flush at CALC iteration 10 -> IDLE next edge, out_valid never asserted; rst = 0 mid-CALC -> same; MUL 3 x 4 with rd = 0 -> out_data 0.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: 1 bit per cycle, magnitudes in the
// datapath, sign fix-up in a single correction cycle, registered result port.
module mul_div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_data
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned PW = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state, state_d;
  logic            out_valid_d;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  logic            neg_q;
  logic [XLEN-1:0] a;
  logic [PW-1:0]   acc;

  logic            s1, s2, n1, n2;
  logic [XLEN-1:0] m1, m2;
  logic            div_zero, div_ovf, bypass, start_neg, accept, last;
  logic [XLEN-1:0] bypass_val;

  // Request decode: operand signedness, magnitudes and special-case divides
  assign in_ready   = (state == IDLE);
  assign accept     = (state == IDLE) && in_valid && !flush;
  assign last       = (cnt == CW'(XLEN - 1));
  assign s1         = op[2] ? ~op[0] : (op[1:0] != 2'd3);
  assign s2         = op[2] ? ~op[0] : ~op[1];
  assign n1         = s1 & src1[XLEN-1];
  assign n2         = s2 & src2[XLEN-1];
  assign m1         = n1 ? -src1 : src1;
  assign m2         = n2 ? -src2 : src2;
  assign div_zero   = op[2] && (src2 == '0);
  assign div_ovf    = op[2] && !op[0] && (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (&src2);
  assign bypass     = div_zero || div_ovf;
  assign bypass_val = op[1] ? (div_zero ? src1 : '0) : (div_zero ? '1 : src1);
  assign start_neg  = (op[2] && op[1]) ? n1 : (n1 ^ n2);

  // One shift-add multiply step and one restoring divide step
  logic [XLEN:0]   mul_sum;
  logic [PW-1:0]   mul_step, div_step;
  logic [XLEN:0]   rem_sh;
  logic            rem_ge;
  logic [XLEN-1:0] rem_diff;

  assign mul_sum  = {1'b0, acc[PW-1:XLEN]} + (acc[0] ? {1'b0, a} : '0);
  assign mul_step = {mul_sum, acc[XLEN-1:1]};
  assign rem_sh   = acc[PW-1:XLEN-1];
  assign rem_ge   = (rem_sh >= {1'b0, a});
  assign rem_diff = rem_sh[XLEN-1:0] - a;
  assign div_step = rem_ge ? {rem_diff, acc[XLEN-2:0], 1'b1} : {acc[PW-2:0], 1'b0};

  // Sign correction and result selection for the FIX cycle
  logic [PW-1:0]   prod_fix;
  logic [XLEN-1:0] result;

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    result   = '0;
    case (op_q)
      3'd0:           result = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3: result = prod_fix[PW-1:XLEN];
      3'd4, 3'd5:     result = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      default:        result = neg_q ? -acc[PW-1:XLEN] : acc[PW-1:XLEN];
    endcase
  end

  // Next-state and out_valid logic
  always_comb begin
    state_d     = state;
    out_valid_d = out_valid;
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) state_d = bypass ? DONE : CALC;
        CALC: if (last) state_d = FIX;
        FIX: begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
        DONE: begin
          if (!out_valid) begin
            out_valid_d = 1'b1;
          end else if (out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and out_valid registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      out_valid <= out_valid_d;
    end
  end

  // Datapath: latch on accept, iterate in CALC, write result in FIX
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      a        <= '0;
      acc      <= '0;
      out_rd   <= '0;
      out_data <= '0;
    end else if (accept) begin
      cnt    <= '0;
      op_q   <= op;
      rd_q   <= rd;
      out_rd <= rd;
      neg_q  <= start_neg;
      a      <= op[2] ? m2 : m1;
      acc    <= {{XLEN{1'b0}}, (op[2] ? m1 : m2)};
      if (bypass) out_data <= (rd == 5'd0) ? '0 : bypass_val;
    end else if (!flush) begin
      if (state == CALC) begin
        acc <= op_q[2] ? div_step : mul_step;
        cnt <= cnt + CW'(1);
      end else if (state == FIX) begin
        out_data <= (rd_q == 5'd0) ? '0 : result;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with hand-computed expected results.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [4:0]  rd;
  logic [31:0] src1, src2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .src1(src1), .src2(src2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one accept edge, then scramble the inputs
  task automatic issue(input logic [2:0] o, input logic [4:0] r,
                       input logic [31:0] a, input logic [31:0] b);
    op = o; rd = r; src1 = a; src2 = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op = 3'($urandom); rd = 5'($urandom); src1 = $urandom; src2 = $urandom;
  endtask

  // Count edges until out_valid, bounded
  task automatic wait_valid(input string tag, input int exp_edges);
    int n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_edges));
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [4:0] r,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat);
    issue(o, r, a, b);
    wait_valid(tag, lat);
    check({tag, "_data"}, out_data, exp);
    check({tag, "_rd"}, 32'(out_rd), 32'(r));
    tick();
    check({tag, "_idle"}, 32'({in_ready, out_valid}), 32'(2'b10));
  endtask

  initial begin
    bit seen;
    rst = 1'b0; in_valid = 1'b0; op = '0; rd = '0; src1 = '0; src2 = '0;
    flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_out_rd", 32'(out_rd), 32'd0);
    rst = 1'b1;
    tick();

    run("mul",    3'd0, 5'd5, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run("mulh",   3'd1, 5'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run("mulhu",  3'd3, 5'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run("mulhsu", 3'd2, 5'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run("mul_big", 3'd0, 5'd9, 32'h00012345, 32'h00010000, 32'h23450000, 33);
    run("div",    3'd4, 5'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run("rem",    3'd6, 5'd7, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run("divu",   3'd5, 5'd8, 32'd100,      32'd7,        32'd14,       33);
    run("remu",   3'd7, 5'd9, 32'd100,      32'd7,        32'd2,        33);
    run("div_neg_div", 3'd4, 5'd10, 32'd20, 32'hFFFFFFFA, 32'hFFFFFFFD, 33);
    run("divu_zero", 3'd5, 5'd11, 32'd9,    32'd0,        32'hFFFFFFFF, 1);
    run("rem_zero",  3'd6, 5'd12, 32'd5,    32'd0,        32'd5,        1);
    run("div_ovf",   3'd4, 5'd13, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run("rem_ovf",   3'd6, 5'd14, 32'h80000000, 32'hFFFFFFFF, 32'd0,    1);
    run("mul_rd0",   3'd0, 5'd0,  32'd3,    32'd4,        32'd0,        33);

    // Backpressure: result must hold for 10 cycles
    out_ready = 1'b0;
    issue(3'd0, 5'd3, 32'd6, 32'd7);
    wait_valid("bp", 33);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", out_data, 32'h0000002A);
      check("bp_hold_rd", 32'(out_rd), 32'd3);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_release", 32'({in_ready, out_valid}), 32'(2'b10));

    // Flush at CALC iteration 10
    issue(3'd0, 5'd2, 32'd3, 32'd5);
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_idle", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check("flush_no_result", 32'(seen), 32'd0);
    run("after_flush", 3'd5, 5'd4, 32'd100, 32'd7, 32'd14, 33);

    // Flush beats in_valid in IDLE
    in_valid = 1'b1; flush = 1'b1; op = 3'd0; rd = 5'd1; src1 = 32'd1; src2 = 32'd1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_beats_valid", 32'(in_ready), 32'd1);
    tick();
    check("flush_beats_valid2", 32'({in_ready, out_valid}), 32'(2'b10));

    // Reset mid-CALC
    issue(3'd4, 5'd6, 32'd1000, 32'd3);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst_calc_in_ready", 32'(in_ready), 32'd1);
    check("rst_calc_out_rd", 32'(out_rd), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check("rst_calc_no_result", 32'(seen), 32'd0);

    // Reset while holding a result in DONE
    out_ready = 1'b0;
    issue(3'd5, 5'd4, 32'd9, 32'd0);
    wait_valid("rst_done", 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    check("rst_done_state", 32'({in_ready, out_valid}), 32'(2'b10));
    check("rst_done_data", out_data, 32'd0);
    run("after_rst", 3'd0, 5'd5, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
